ball_physics: RTL and testbench



---
 rtl/ball_physics_if.sv | 23 ++
 rtl/ball_physics.sv | 185 ++++++++++++++++++
 tb/tb_ball_physics.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/ball_physics_if.sv
// Frame-tick, bar-position and ball/score signals between the Pong game logic
// and its neighbours (bar renderers, ball renderer, Nios result bus).
interface ball_physics_if;
  logic        i_frame;
  logic [8:0]  i_bar1_y;
  logic [8:0]  i_bar2_y;
  logic [9:0]  o_ball_x;
  logic [8:0]  o_ball_y;
  logic [3:0]  o_score1;
  logic [3:0]  o_score2;
  logic        o_game_over;
  logic [31:0] o_result;

  modport master (
    output i_frame, i_bar1_y, i_bar2_y,
    input  o_ball_x, o_ball_y, o_score1, o_score2, o_game_over, o_result
  );

  modport slave (
    input  i_frame, i_bar1_y, i_bar2_y,
    output o_ball_x, o_ball_y, o_score1, o_score2, o_game_over, o_result
  );
endinterface

// File: rtl/ball_physics.sv
// Pong ball/score engine: serve delay, per-frame motion, wall and bar bounces,
// goals and a saturating score, all advanced only on the frame tick.
module ball_physics #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int BALL_SIZE    = 8,
  parameter int BAR_H        = 60,
  parameter int BAR_W        = 10,
  parameter int BAR1_X       = 10,
  parameter int BAR2_X       = 620,
  parameter int SPEED        = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int SCORE_MAX    = 9
) (
  input  logic           i_clk,
  input  logic           i_rst,
  ball_physics_if.slave  bus
);

  localparam int CW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

  localparam logic [9:0] X_CENTRE  = 10'((H_RES - BALL_SIZE) / 2);
  localparam logic [8:0] Y_CENTRE  = 9'((V_RES - BALL_SIZE) / 2);
  localparam logic [8:0] Y_MAX     = 9'(V_RES - BALL_SIZE);
  localparam logic [9:0] BAR1_EDGE = 10'(BAR1_X + BAR_W);
  localparam logic [9:0] BAR1_NEAR = 10'(BAR1_X + BAR_W + SPEED);
  localparam logic [9:0] BAR2_STOP = 10'(BAR2_X - BALL_SIZE);
  localparam logic [9:0] BAR2_X10  = 10'(BAR2_X);
  localparam logic [9:0] STEP_SPAN = 10'(BALL_SIZE + SPEED);
  localparam logic [9:0] H_RES10   = 10'(H_RES);
  localparam logic [9:0] V_RES10   = 10'(V_RES);
  localparam logic [9:0] BAR_H_M1  = 10'(BAR_H - 1);
  localparam logic [9:0] BALL_M1   = 10'(BALL_SIZE - 1);
  localparam logic [9:0] SPEED10   = 10'(SPEED);
  localparam logic [8:0] SPEED9    = 9'(SPEED);
  localparam logic [3:0] SMAX      = 4'(SCORE_MAX);
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);

  typedef enum logic [1:0] {SERVE, MOVE, SCORED, OVER} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [9:0]    ball_x_reg;
  logic [8:0]    ball_y_reg;
  logic          dx_reg;      // 1 = moving right
  logic          dy_reg;      // 1 = moving down
  logic [3:0]    score1_reg;
  logic [3:0]    score2_reg;
  logic          game_over_reg;
  logic          p2_scored_reg;

  logic [9:0] y10, bar1_10, bar2_10;
  logic       overlap1, overlap2, hit1, hit2;
  logic [9:0] x_next;
  logic [8:0] y_next;
  logic       dx_next, dy_next, goal_p1, goal_p2;
  logic [3:0] score1_inc, score2_inc;

  assign y10     = {1'b0, ball_y_reg};
  assign bar1_10 = {1'b0, bus.i_bar1_y};
  assign bar2_10 = {1'b0, bus.i_bar2_y};

  // Row ranges [y, y+BALL_SIZE-1] and [bar, bar+BAR_H-1] intersect
  assign overlap1 = (y10 <= bar1_10 + BAR_H_M1) && (bar1_10 <= y10 + BALL_M1);
  assign overlap2 = (y10 <= bar2_10 + BAR_H_M1) && (bar2_10 <= y10 + BALL_M1);

  assign hit1 = (ball_x_reg < BAR1_NEAR) && (ball_x_reg >= BAR1_EDGE) && overlap1;
  assign hit2 = (ball_x_reg + STEP_SPAN > BAR2_X10) && (ball_x_reg <= BAR2_STOP) && overlap2;

  assign score1_inc = (score1_reg == SMAX) ? score1_reg : score1_reg + 4'd1;
  assign score2_inc = (score2_reg == SMAX) ? score2_reg : score2_reg + 4'd1;

  always_comb begin
    y_next  = ball_y_reg;
    dy_next = dy_reg;
    x_next  = ball_x_reg;
    dx_next = dx_reg;
    goal_p1 = 1'b0;
    goal_p2 = 1'b0;

    if (!dy_reg) begin
      if (ball_y_reg < SPEED9) begin
        y_next  = 9'd0;
        dy_next = 1'b1;
      end else begin
        y_next = ball_y_reg - SPEED9;
      end
    end else begin
      if (y10 + STEP_SPAN > V_RES10) begin
        y_next  = Y_MAX;
        dy_next = 1'b0;
      end else begin
        y_next = ball_y_reg + SPEED9;
      end
    end

    if (!dx_reg) begin
      if (hit1) begin
        x_next  = BAR1_EDGE;
        dx_next = 1'b1;
      end else if (ball_x_reg < SPEED10) begin
        goal_p2 = 1'b1;
      end else begin
        x_next = ball_x_reg - SPEED10;
      end
    end else begin
      if (hit2) begin
        x_next  = BAR2_STOP;
        dx_next = 1'b0;
      end else if (ball_x_reg + STEP_SPAN > H_RES10) begin
        goal_p1 = 1'b1;
      end else begin
        x_next = ball_x_reg + SPEED10;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= SERVE;
      cnt_reg       <= '0;
      ball_x_reg    <= X_CENTRE;
      ball_y_reg    <= Y_CENTRE;
      dx_reg        <= 1'b1;
      dy_reg        <= 1'b1;
      score1_reg    <= 4'd0;
      score2_reg    <= 4'd0;
      game_over_reg <= 1'b0;
      p2_scored_reg <= 1'b0;
    end else if (bus.i_frame) begin
      case (state_reg)
        SERVE: begin
          if (cnt_reg == SERVE_LAST) begin
            cnt_reg   <= '0;
            state_reg <= MOVE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        MOVE: begin
          ball_y_reg <= y_next;
          dy_reg     <= dy_next;
          // A goal freezes x where it was; the ball is re-centred next frame
          if (goal_p2) begin
            score2_reg    <= score2_inc;
            game_over_reg <= (score2_inc == SMAX) || (score1_reg == SMAX);
            p2_scored_reg <= 1'b1;
            state_reg     <= SCORED;
          end else if (goal_p1) begin
            score1_reg    <= score1_inc;
            game_over_reg <= (score1_inc == SMAX) || (score2_reg == SMAX);
            p2_scored_reg <= 1'b0;
            state_reg     <= SCORED;
          end else begin
            ball_x_reg <= x_next;
            dx_reg     <= dx_next;
          end
        end
        SCORED: begin
          ball_x_reg <= X_CENTRE;
          ball_y_reg <= Y_CENTRE;
          cnt_reg    <= '0;
          if (game_over_reg) begin
            state_reg <= OVER;
          end else begin
            // Serve toward the player who just conceded
            dx_reg    <= !p2_scored_reg;
            state_reg <= SERVE;
          end
        end
        default: begin
          state_reg <= OVER;
        end
      endcase
    end
  end

  assign bus.o_ball_x    = ball_x_reg;
  assign bus.o_ball_y    = ball_y_reg;
  assign bus.o_score1    = score1_reg;
  assign bus.o_score2    = score2_reg;
  assign bus.o_game_over = game_over_reg;
  assign bus.o_result    = {23'b0, game_over_reg, score2_reg, score1_reg};

endmodule

// File: tb/tb_ball_physics.sv
// Randomised play of ball_physics against a frame-level reference of the game,
// with expected outputs queued per tick and checked by an independent monitor.
module tb_ball_physics;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ball_physics_if bus();

  ball_physics dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    int x;
    int y;
    int s1;
    int s2;
    int go;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  bit   have_cur = 1'b0;
  int   total = 0;
  int   bad = 0;

  // Reference game: position, velocity in pixels/frame, scores, serve wait
  int m_x, m_y, m_vx, m_vy, m_s1, m_s2, m_wait, m_pend;
  bit m_over;

  function automatic void model_reset();
    m_x = 316; m_y = 236; m_vx = 2; m_vy = 2;
    m_s1 = 0; m_s2 = 0; m_wait = 60; m_pend = 0; m_over = 1'b0;
  endfunction

  function automatic bit rows_meet(int by, int bar);
    return (by <= bar + 59) && (bar <= by + 7);
  endfunction

  function automatic void model_frame(int b1, int b2);
    int ny;
    if (m_over) return;
    if (m_pend != 0) begin
      m_x = 316; m_y = 236;
      if (m_s1 == 9 || m_s2 == 9) m_over = 1'b1;
      else begin
        m_vx = (m_pend == 2) ? -2 : 2;
        m_wait = 60;
      end
      m_pend = 0;
      return;
    end
    if (m_wait > 0) begin
      m_wait--;
      return;
    end
    if (m_vy < 0 && m_y < 2) begin ny = 0; m_vy = 2; end
    else if (m_vy > 0 && m_y + 10 > 480) begin ny = 472; m_vy = -2; end
    else ny = m_y + m_vy;
    if (m_vx < 0) begin
      if (m_x >= 20 && m_x - 2 < 20 && rows_meet(m_y, b1)) begin m_x = 20; m_vx = 2; end
      else if (m_x < 2) begin m_s2 = (m_s2 < 9) ? m_s2 + 1 : 9; m_pend = 2; end
      else m_x = m_x - 2;
    end else begin
      if (m_x + 8 <= 620 && m_x + 10 > 620 && rows_meet(m_y, b2)) begin m_x = 612; m_vx = -2; end
      else if (m_x + 10 > 640) begin m_s1 = (m_s1 < 9) ? m_s1 + 1 : 9; m_pend = 1; end
      else m_x = m_x + 2;
    end
    m_y = ny;
  endfunction

  function automatic exp_t model_view();
    exp_t e;
    e.x = m_x; e.y = m_y; e.s1 = m_s1; e.s2 = m_s2;
    e.go = (m_s1 == 9 || m_s2 == 9) ? 1 : 0;
    return e;
  endfunction

  task automatic check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_all(string tag);
    int res_req;
    res_req = (cur.go << 8) | (cur.s2 << 4) | cur.s1;
    check({tag, "_x"}, int'(bus.o_ball_x), cur.x);
    check({tag, "_y"}, int'(bus.o_ball_y), cur.y);
    check({tag, "_s1"}, int'(bus.o_score1), cur.s1);
    check({tag, "_s2"}, int'(bus.o_score2), cur.s2);
    check({tag, "_over"}, int'(bus.o_game_over), cur.go);
    check({tag, "_result"}, int'(bus.o_result), res_req);
  endtask

  // Monitor: outputs present one cycle after a frame tick or reset
  logic ev_q = 1'b0;
  always @(posedge clk) ev_q <= bus.i_frame || rst;

  always @(negedge clk) begin
    if (ev_q) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty actual=0 required=1");
      end else begin
        cur = sb.pop_front();
        have_cur = 1'b1;
        check_all("tick");
        $display("tick x=%0d y=%0d s1=%0d s2=%0d over=%0d", bus.o_ball_x, bus.o_ball_y,
                 bus.o_score1, bus.o_score2, bus.o_game_over);
      end
    end else if (have_cur) begin
      check_all("hold");
    end
  end

  task automatic apply(bit r, bit f, int b1, int b2);
    @(posedge clk);
    #1;
    rst = r;
    bus.i_frame = f;
    bus.i_bar1_y = 9'(b1);
    bus.i_bar2_y = 9'(b2);
    if (r) model_reset();
    else if (f) model_frame(b1, b2);
    if (r || f) sb.push_back(model_view());
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.i_frame = 1'b0;
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  function automatic int pick_bar();
    int v;
    if ($urandom_range(0, 3) == 0) begin
      v = m_y - int'($urandom_range(0, 66));
      if (v < 0) v = 0;
      if (v > 420) v = 420;
    end else begin
      v = int'($urandom_range(0, 511));
    end
    return v;
  endfunction

  initial begin
    int n;
    bus.i_frame = 1'b0;
    bus.i_bar1_y = 9'd0;
    bus.i_bar2_y = 9'd0;
    model_reset();

    apply(1'b1, 1'b0, 0, 0);
    // Serve delay and first motion step
    for (int i = 0; i < 61; i++) apply(1'b0, 1'b1, pick_bar(), pick_bar());

    n = 0;
    while (!m_over && n < 8000) begin
      if (n == 300) apply(1'b1, 1'b1, pick_bar(), pick_bar());
      else apply(1'b0, 1'b1, pick_bar(), pick_bar());
      n++;
    end
    // Game over must freeze everything
    for (int i = 0; i < 20; i++) apply(1'b0, 1'b1, pick_bar(), pick_bar());
    apply(1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, pick_bar(), pick_bar());

    repeat (4) @(posedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
